// File: rtl/fft_frame_serializer.sv
// fft_frame_serializer: takes one full N-sample complex frame in a single
// val/rdy transfer and streams it out one sample per transfer.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   recv_msg_real/imag [N]      parallel frame input (raw bits)
//   recv_val / recv_rdy         frame handshake
//   send_msg_real/imag          current sample
//   send_idx                    output position k of the current sample
//   send_last                   high on the final sample of a frame
//   send_val / send_rdy         sample handshake
//
// With BIT_REVERSE=1, output position k carries buffer slot bitrev(k).
// recv_rdy depends combinationally on send_rdy so that a new frame can
// be captured on the same edge as the final sample of the old one.
module fft_frame_serializer #(
  parameter int BIT_WIDTH   = 32,
  parameter int N_SAMPLES   = 8,
  parameter bit BIT_REVERSE = 1'b0,
  localparam int IW = $clog2(N_SAMPLES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] recv_msg_real [N_SAMPLES-1:0],
  input  logic [BIT_WIDTH-1:0] recv_msg_imag [N_SAMPLES-1:0],
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic [BIT_WIDTH-1:0] send_msg_real,
  output logic [BIT_WIDTH-1:0] send_msg_imag,
  output logic [IW-1:0]        send_idx,
  output logic                 send_last,
  output logic                 send_val,
  input  logic                 send_rdy
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(N_SAMPLES - 1);

  state_t state;
  state_t state_next;

  logic [IW-1:0]        cnt;
  logic [IW-1:0]        sel;
  logic [BIT_WIDTH-1:0] frame_real [N_SAMPLES-1:0];
  logic [BIT_WIDTH-1:0] frame_imag [N_SAMPLES-1:0];

  logic accept;
  logic fire;
  logic at_last;

  function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] v);
    logic [IW-1:0] r;
    for (int i = 0; i < IW; i++) begin
      r[i] = v[IW-1-i];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign at_last = (cnt == LAST);

  always_comb begin
    state_next = state;
    recv_rdy   = 1'b0;
    send_val   = 1'b0;
    send_last  = 1'b0;
    unique case (state)
      IDLE: begin
        recv_rdy = 1'b1;
        if (recv_val) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        send_val  = 1'b1;
        send_last = at_last;
        recv_rdy  = at_last & send_rdy;
        // Last sample leaving with no frame waiting empties the buffer.
        if (send_rdy && at_last && !recv_val) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign accept = recv_val & recv_rdy;
  assign fire   = send_val & send_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      for (int i = 0; i < N_SAMPLES; i++) begin
        frame_real[i] <= '0;
        frame_imag[i] <= '0;
      end
    end else begin
      if (accept) begin
        cnt        <= '0;
        frame_real <= recv_msg_real;
        frame_imag <= recv_msg_imag;
      end else if (fire) begin
        // Wraps to 0 after the last sample.
        cnt <= cnt + IW'(1);
      end
    end
  end

  assign sel = BIT_REVERSE ? bitrev(cnt) : cnt;

  assign send_idx      = cnt;
  assign send_msg_real = frame_real[sel];
  assign send_msg_imag = frame_imag[sel];

endmodule

// File: tb/tb_fft_frame_serializer.sv
// tb_fft_frame_serializer: directed bench for fft_frame_serializer.
// Runs an in-order and a bit-reversed instance on shared stimulus.
module tb_fft_frame_serializer;

  localparam int BW = 32;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] rr [N-1:0];
  logic [BW-1:0] ri [N-1:0];
  logic          recv_val;
  logic          send_rdy;

  logic          recv_rdy, recv_rdy_b;
  logic [BW-1:0] out_r, out_i, out_r_b, out_i_b;
  logic [2:0]    idx, idx_b;
  logic          last, last_b;
  logic          sval, sval_b;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fft_frame_serializer #(
    .BIT_WIDTH(BW), .N_SAMPLES(N), .BIT_REVERSE(1'b0)
  ) dut (
    .clk(clk), .reset(reset),
    .recv_msg_real(rr), .recv_msg_imag(ri),
    .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg_real(out_r), .send_msg_imag(out_i),
    .send_idx(idx), .send_last(last),
    .send_val(sval), .send_rdy(send_rdy)
  );

  fft_frame_serializer #(
    .BIT_WIDTH(BW), .N_SAMPLES(N), .BIT_REVERSE(1'b1)
  ) dut_br (
    .clk(clk), .reset(reset),
    .recv_msg_real(rr), .recv_msg_imag(ri),
    .recv_val(recv_val), .recv_rdy(recv_rdy_b),
    .send_msg_real(out_r_b), .send_msg_imag(out_i_b),
    .send_idx(idx_b), .send_last(last_b),
    .send_val(sval_b), .send_rdy(send_rdy)
  );

  // Advance one edge; inputs are driven 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input logic [BW-1:0] br,
                           input logic [BW-1:0] bi);
    for (int i = 0; i < N; i++) begin
      rr[i] = br + BW'(i);
      ri[i] = bi + BW'(i);
    end
  endtask

  // Present the current frame and let it be captured on the next edge.
  task automatic load();
    recv_val = 1'b1;
    step();
    recv_val = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    recv_val = 1'b0;
    send_rdy = 1'b0;
    set_frame(32'hdead_0000, 32'hbeef_0000);
    step();
    step();
    reset = 1'b0;
    #1;
    nvec++;
    if (recv_rdy !== 1'b1 || sval !== 1'b0 || idx !== 3'd0 ||
        last !== 1'b0 || out_r !== 0 || out_i !== 0) begin
      $display("FAIL reset: rdy=%b val=%b idx=%0d last=%b r=%h i=%h, want 1 0 0 0 0 0",
               recv_rdy, sval, idx, last, out_r, out_i);
      nerr++;
    end
    step();
  endtask

  task automatic test_single();
    set_frame(32'h100, 32'h200);
    send_rdy = 1'b1;
    load();
    for (int k = 0; k < N; k++) begin
      #1;
      nvec++;
      if (sval !== 1'b1 || idx !== 3'(k) || out_r !== 32'h100 + k ||
          out_i !== 32'h200 + k || last !== (k == 7) ||
          recv_rdy !== (k == 7)) begin
        $display("FAIL single k=%0d: val=%b idx=%0d r=%h i=%h last=%b rdy=%b",
                 k, sval, idx, out_r, out_i, last, recv_rdy);
        nerr++;
      end
      step();
    end
    #1;
    nvec++;
    if (sval !== 1'b0 || recv_rdy !== 1'b1) begin
      $display("FAIL single_idle: val=%b rdy=%b, want 0 1", sval, recv_rdy);
      nerr++;
    end
  endtask

  task automatic test_backpressure();
    logic pat [4];
    int   ek;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    ek = 0;
    set_frame(32'h100, 32'h200);
    send_rdy = 1'b1;
    load();
    for (int c = 0; c < 40 && ek < N; c++) begin
      send_rdy = pat[c % 4];
      #1;
      nvec++;
      if (sval !== 1'b1 || idx !== 3'(ek) || out_r !== 32'h100 + ek ||
          out_i !== 32'h200 + ek ||
          recv_rdy !== (ek == 7 && send_rdy)) begin
        $display("FAIL backpressure c=%0d: idx=%0d r=%h rdy=%b, want idx=%0d r=%h",
                 c, idx, out_r, recv_rdy, ek, 32'h100 + ek);
        nerr++;
      end
      if (send_rdy) ek++;
      step();
    end
    nvec++;
    if (ek != N || sval !== 1'b0) begin
      $display("FAIL backpressure_done: samples=%0d val=%b, want 8 0", ek, sval);
      nerr++;
    end
    send_rdy = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] er;
    set_frame(32'h0, 32'h0);
    send_rdy = 1'b1;
    recv_val = 1'b1;
    step();
    set_frame(32'h10, 32'h0);
    for (int k = 0; k < 2 * N; k++) begin
      if (k == N) recv_val = 1'b0;
      er = (k < N) ? BW'(k) : BW'(32'h10 + k - N);
      #1;
      nvec++;
      if (sval !== 1'b1 || out_r !== er || idx !== 3'(k % N) ||
          recv_rdy !== (k == 7 || k == 15)) begin
        $display("FAIL b2b k=%0d: val=%b r=%h idx=%0d rdy=%b, want r=%h",
                 k, sval, out_r, idx, recv_rdy, er);
        nerr++;
      end
      step();
    end
    recv_val = 1'b0;
    #1;
    nvec++;
    if (sval !== 1'b0) begin
      $display("FAIL b2b_idle: val=%b, want 0", sval);
      nerr++;
    end
  endtask

  task automatic test_bit_reverse();
    logic [BW-1:0] rev [N];
    rev = '{0, 4, 2, 6, 1, 5, 3, 7};
    set_frame(32'h0, 32'h40);
    send_rdy = 1'b1;
    load();
    for (int k = 0; k < N; k++) begin
      #1;
      nvec++;
      if (sval_b !== 1'b1 || idx_b !== 3'(k) || out_r_b !== rev[k] ||
          out_i_b !== 32'h40 + rev[k] || last_b !== (k == 7)) begin
        $display("FAIL bitrev k=%0d: idx=%0d r=%h i=%h last=%b, want r=%h",
                 k, idx_b, out_r_b, out_i_b, last_b, rev[k]);
        nerr++;
      end
      step();
    end
  endtask

  task automatic test_ignored();
    set_frame(32'h100, 32'h200);
    send_rdy = 1'b1;
    load();
    for (int k = 0; k < 3; k++) step();
    send_rdy = 1'b0;
    recv_val = 1'b1;
    set_frame(32'h300, 32'h400);
    #1;
    nvec++;
    if (recv_rdy !== 1'b0 || idx !== 3'd3 || out_r !== 32'h103) begin
      $display("FAIL ignored_hold: rdy=%b idx=%0d r=%h, want 0 3 103",
               recv_rdy, idx, out_r);
      nerr++;
    end
    step();
    send_rdy = 1'b1;
    for (int k = 3; k < N; k++) begin
      #1;
      nvec++;
      if (idx !== 3'(k) || out_r !== 32'h100 + k || recv_rdy !== (k == 7)) begin
        $display("FAIL ignored_orig k=%0d: idx=%0d r=%h rdy=%b",
                 k, idx, out_r, recv_rdy);
        nerr++;
      end
      step();
    end
    recv_val = 1'b0;
    for (int k = 0; k < N; k++) begin
      #1;
      nvec++;
      if (sval !== 1'b1 || idx !== 3'(k) || out_r !== 32'h300 + k) begin
        $display("FAIL ignored_new k=%0d: val=%b idx=%0d r=%h, want r=%h",
                 k, sval, idx, out_r, 32'h300 + k);
        nerr++;
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    set_frame(32'h100, 32'h200);
    send_rdy = 1'b1;
    load();
    for (int k = 0; k < 4; k++) step();
    #1;
    nvec++;
    if (idx !== 3'd4 || out_r !== 32'h104) begin
      $display("FAIL rstmid_pre: idx=%0d r=%h, want 4 104", idx, out_r);
      nerr++;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    nvec++;
    if (sval !== 1'b0 || recv_rdy !== 1'b1 || idx !== 3'd0) begin
      $display("FAIL rstmid_post: val=%b rdy=%b idx=%0d, want 0 1 0",
               sval, recv_rdy, idx);
      nerr++;
    end
    set_frame(32'h500, 32'h600);
    load();
    for (int k = 0; k < N; k++) begin
      #1;
      nvec++;
      if (sval !== 1'b1 || idx !== 3'(k) || out_r !== 32'h500 + k ||
          out_i !== 32'h600 + k) begin
        $display("FAIL rstmid_frame k=%0d: idx=%0d r=%h i=%h",
                 k, idx, out_r, out_i);
        nerr++;
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_bit_reverse();
    test_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, want completion");
    $fatal(1);
  end

endmodule
